// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two ALU requesters and the shared-ALU arbiter.
// master: requester side (drives requests, accepts responses).
// slave:  arbiter side.
interface alu_share_arbiter_if;
  // Requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_op1;
  logic [31:0] req0_op2;
  logic [2:0]  req0_aluop;
  logic        rsp0_valid;
  logic        rsp0_ready;
  // Requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_op1;
  logic [31:0] req1_op2;
  logic [2:0]  req1_aluop;
  logic        rsp1_valid;
  logic        rsp1_ready;
  // Shared response payload
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_aluop, rsp0_ready,
    output req1_valid, req1_op1, req1_op2, req1_aluop, rsp1_ready,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_aluop, rsp0_ready,
    input  req1_valid, req1_op1, req1_op2, req1_aluop, rsp1_ready,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shared 32-bit ALU with a two-requester round-robin arbiter.
// Sequence per operation: IDLE (grant + capture) -> EXEC (evaluate) -> RESP (hold result).
// Priority flips only when a response completes, so a lone requester cannot starve the other.
module alu_share_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e      r_state;
  logic        r_prio;
  logic        r_owner;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [2:0]  r_aluop;
  logic [31:0] r_result;
  logic        r_zero;

  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic [31:0] w_alu_result;
  logic        w_rsp_accept;
  logic        w_idle;

  assign w_idle = (r_state == StIdle);

  // Grant selection: a lone valid wins outright, a tie goes to the priority holder.
  always_comb begin
    w_gnt_valid = bus.req0_valid | bus.req1_valid;
    w_gnt_id    = r_prio;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_gnt_id = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      w_gnt_id = 1'b1;
    end
  end

  // Ready depends only on state, valids and prio; never on response readiness.
  assign bus.req0_ready = w_idle && w_gnt_valid && !w_gnt_id;
  assign bus.req1_ready = w_idle && w_gnt_valid &&  w_gnt_id;

  // ALU evaluated from the captured operands; unassigned opcodes yield zero.
  always_comb begin
    unique case (r_aluop)
      3'b000:  w_alu_result = r_op1 + r_op2;
      3'b001:  w_alu_result = r_op1 - r_op2;
      3'b010:  w_alu_result = r_op1 & r_op2;
      3'b011:  w_alu_result = r_op1 | r_op2;
      default: w_alu_result = 32'd0;
    endcase
  end

  // Only the owner's ready can complete the response.
  assign w_rsp_accept = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  // Sequencer: grant/capture, evaluate, then hold the response until its owner takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_prio   <= RR_INIT;
      r_owner  <= 1'b0;
      r_op1    <= 32'd0;
      r_op2    <= 32'd0;
      r_aluop  <= 3'd0;
      r_result <= 32'd0;
      r_zero   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_gnt_valid) begin
            r_owner <= w_gnt_id;
            if (w_gnt_id) begin
              r_op1   <= bus.req1_op1;
              r_op2   <= bus.req1_op2;
              r_aluop <= bus.req1_aluop;
            end else begin
              r_op1   <= bus.req0_op1;
              r_op2   <= bus.req0_op2;
              r_aluop <= bus.req0_aluop;
            end
            r_state <= StExec;
          end
        end
        StExec: begin
          r_result <= w_alu_result;
          r_zero   <= (w_alu_result == 32'd0);
          r_state  <= StResp;
        end
        StResp: begin
          if (w_rsp_accept) begin
            r_prio  <= ~r_owner;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rsp0_valid = (r_state == StResp) && !r_owner;
  assign bus.rsp1_valid = (r_state == StResp) &&  r_owner;
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign o_busy         = !w_idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: latency, arithmetic, arbitration order,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_checks;
  int   n_fail;

  alu_share_arbiter_if bus ();

  alu_share_arbiter #(
    .RR_INIT (1'b0)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit port, input logic vld, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
    if (!port) begin
      bus.req0_valid = vld; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_aluop = op;
    end else begin
      bus.req1_valid = vld; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_aluop = op;
    end
  endtask

  // One complete operation with zero-wait response ready; checks the N / N+2 latency.
  task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp_r, input logic exp_z,
                        input string tag);
    logic rdy;
    @(negedge clk);
    drive_req(port, 1'b1, a, b, op);
    if (!port) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    #1;
    rdy = port ? bus.req1_ready : bus.req0_ready;
    for (int i = 0; i < 8 && !rdy; i++) begin
      @(negedge clk);
      #1;
      rdy = port ? bus.req1_ready : bus.req0_ready;
    end
    check_eq({tag, "_req_ready"}, 32'(rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_exec_rdy0"}, 32'(bus.req0_ready), 32'd0);
    check_eq({tag, "_exec_rdy1"}, 32'(bus.req1_ready), 32'd0);
    check_eq({tag, "_exec_rspv"}, 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
    drive_req(port, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    check_eq({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid), 32'(!port));
    check_eq({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid), 32'(port));
    check_eq({tag, "_result"}, bus.rsp_result, exp_r);
    check_eq({tag, "_zero"}, 32'(bus.rsp_zero), 32'(exp_z));
    @(negedge clk);
    check_eq({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset values, and ready following the grant rule while in reset.
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check_eq("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check_eq("rst_result", bus.rsp_result, 32'd0);
    check_eq("rst_zero", 32'(bus.rsp_zero), 32'd0);
    check_eq("rst_rdy0_idle", 32'(bus.req0_ready), 32'd0);
    bus.req1_valid = 1'b1;
    #1;
    check_eq("rst_rdy1_lone", 32'(bus.req1_ready), 32'd1);
    check_eq("rst_rdy0_lone", 32'(bus.req0_ready), 32'd0);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 32'd5, 32'd3, 3'b000, 32'd8, 1'b0, "add");
    run_op(1'b1, 32'd7, 32'd7, 3'b001, 32'd0, 1'b1, "sub_zero");
    run_op(1'b1, 32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 1'b0, "sub_wrap");

    // Contention from a fresh reset: order must alternate 0,1,0,1.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'h0F, 32'h3C, 3'b010);
    drive_req(1'b1, 1'b1, 32'h0F, 32'h30, 3'b011);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = k[0];
      #1;
      check_eq($sformatf("cont%0d_rdy0", k), 32'(bus.req0_ready), 32'(!g));
      check_eq($sformatf("cont%0d_rdy1", k), 32'(bus.req1_ready), 32'(g));
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("cont%0d_exec_rdy", k), 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      @(negedge clk);
      check_eq($sformatf("cont%0d_rsp0v", k), 32'(bus.rsp0_valid), 32'(!g));
      check_eq($sformatf("cont%0d_rsp1v", k), 32'(bus.rsp1_valid), 32'(g));
      check_eq($sformatf("cont%0d_result", k), bus.rsp_result, g ? 32'h3F : 32'h0C);
      check_eq($sformatf("cont%0d_resp_rdy", k), 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      @(negedge clk);
    end
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Backpressure: four held RESP cycles, completion on the fifth.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'd10, 32'd20, 3'b000);
    #1;
    check_eq("bp_rdy0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive_req(1'b1, 1'b1, 32'd2, 32'd2, 3'b000);
    @(negedge clk);
    for (int h = 0; h < 4; h++) begin
      check_eq($sformatf("bp%0d_rsp0v", h), 32'(bus.rsp0_valid), 32'd1);
      check_eq($sformatf("bp%0d_rsp1v", h), 32'(bus.rsp1_valid), 32'd0);
      check_eq($sformatf("bp%0d_result", h), bus.rsp_result, 32'd30);
      check_eq($sformatf("bp%0d_busy", h), 32'(busy), 32'd1);
      check_eq($sformatf("bp%0d_rdy", h), 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      bus.rsp1_ready = (h == 1);
      @(negedge clk);
    end
    check_eq("bp5_rsp0v", 32'(bus.rsp0_valid), 32'd1);
    check_eq("bp5_result", bus.rsp_result, 32'd30);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_done_busy", 32'(busy), 32'd0);
    check_eq("bp_done_rsp0v", 32'(bus.rsp0_valid), 32'd0);
    check_eq("bp_done_rdy1", 32'(bus.req1_ready), 32'd1);
    drive_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    bus.rsp0_ready = 1'b0;

    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 32'd0, 1'b1, "illegal");

    // Asynchronous reset during EXEC.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'd4, 32'd5, 3'b000);
    bus.rsp0_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    check_eq("rexec_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rexec_busy", 32'(busy), 32'd0);
    check_eq("rexec_zero", 32'(bus.rsp_zero), 32'd0);
    check_eq("rexec_rsp0v", 32'(bus.rsp0_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset during RESP.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'd4, 32'd5, 3'b000);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    check_eq("rresp_rsp0v_pre", 32'(bus.rsp0_valid), 32'd1);
    check_eq("rresp_result_pre", bus.rsp_result, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rresp_rsp0v", 32'(bus.rsp0_valid), 32'd0);
    check_eq("rresp_busy", 32'(busy), 32'd0);
    check_eq("rresp_result", bus.rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 32'd1, 32'd1, 3'b000, 32'd2, 1'b0, "post_rst_add");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates and sequences the single shared 32-bit integer ALU between two requesters, e.g. the execute stage (port 0) and the branch-compare path (port 1). It registers the granted request's operands and opcode, runs one ALU evaluation, and returns the registered `result`/`zero` to the owning requester over a valid/ready response channel. The ALU is instantiated inside this block: `aluOp` 000 = add, 001 = sub, 010 = and, 011 = or, other codes give result 0; `zero` = (result == 0).

## Interface
- `RR_INIT`, default 0: requester that holds priority after reset (0 or 1).

- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req0_valid`  input  1  requester 0 has an operation pending.
- `req0_ready`  output  1  requester 0 request accepted this cycle when high with valid.
- `req0_op1`, `req0_op2`  input  32 each  requester 0 operands.
- `req0_aluop`  input  3  requester 0 ALU opcode.
- `rsp0_valid`  output  1  result for requester 0 available.
- `rsp0_ready`  input  1  requester 0 takes the result.
- `req1_*` / `rsp1_*`  same widths and meaning for requester 1.
- `rsp_result`  output  32  registered ALU result, shared by both response channels.
- `rsp_zero`  output  1  registered zero flag.
- `busy`  output  1  high whenever state != IDLE.

## Operation
- States:
  - IDLE: no operation in flight.
  - EXEC: ALU evaluates the captured operands.
  - RESP: response held for its owner.
- Priority bit `prio` resets to `RR_INIT`.
- Grant, evaluated in IDLE only:
  - Exactly one valid: grant that requester.
  - Both valid: grant requester `prio`.
  - Neither valid: no grant.
- `reqN_ready` = (state == IDLE) and grant == N. It is combinational from state, valids and `prio`; it has no dependence on any `rsp*_ready`.
- Handshake `reqN_valid & reqN_ready` in IDLE:
  - Captures op1, op2, aluop and owner = N.
  - Next state EXEC.
- EXEC, one cycle:
  - The ALU is driven from the captured registers.
  - `rsp_result` and `rsp_zero` load at the end of the cycle.
  - Next state RESP.
- RESP:
  - `rsp<owner>_valid` = 1; the other `rsp*_valid` = 0.
  - `rsp_result`/`rsp_zero` stay stable until the handshake.
  - On `rsp<owner>_ready`: next state IDLE, `prio` <= ~owner.
- `prio` changes only on response completion. A lone requester therefore cannot starve the other.
- A requester holds valid and operands stable until ready. The block does not check this.
- Opcodes 100–111 are forwarded unchanged; the response is result 0, zero 1.
- Arithmetic: 32-bit modulo. No carry or overflow output; wrap-around is silent.
- `rspN_ready` asserted while the block is not in RESP, or by the non-owner, is ignored.
- Reset mid-operation (any state): immediately IDLE, pending response dropped, `prio` = `RR_INIT`.

## Timing
- Reset values:
  - State IDLE, `busy` 0.
  - `rsp0_valid`, `rsp1_valid` 0.
  - `rsp_result` 0, `rsp_zero` 0.
  - Captured regs 0.
- `req*_ready` after reset follows the grant rule directly.
- Latency:
  - Request handshake at edge N.
  - EXEC during cycle N+1.
  - `rspN_valid` high from cycle N+2.
- Zero-wait response ready: next request handshake at cycle N+3, the earliest.
- Peak throughput: one operation per 3 cycles.
- Backpressure extends RESP indefinitely with outputs stable.
- No request is accepted while `busy` = 1.

## Test plan
- Single add: req0 op1=5, op2=3, aluop=000, rsp0_ready held 1.
  - Expect req0_ready=1 at handshake.
  - Expect rsp0_valid at N+2 with rsp_result=8, rsp_zero=0.
  - Expect rsp1_valid=0 throughout.
- Sub to zero plus wrap:
  - req1 7−7 -> result 0, zero 1.
  - Then req1 0−1 -> result 0xFFFFFFFF, zero 0.
- Contention: both valid continuously from reset (RR_INIT=0), req0 0x0F&0x3C, req1 0x0F|0x30.
  - Expect service order req0 (0x0C), req1 (0x3F), req0, req1.
  - Expect the non-granted ready to be 0 throughout.
- Backpressure:
  - Hold rsp0_ready=0 for 4 cycles in RESP.
  - Expect rsp0_valid, rsp_result and busy stable; both req*_ready stay 0; completion on the 5th cycle.
  - rsp1_ready pulsed during the hold has no effect.
- Illegal opcode: aluop=101, op1=op2=0xFFFFFFFF -> rsp_result 0, rsp_zero 1.
- Reset mid-op:
  - Assert rst_n=0 asynchronously during EXEC, then again during RESP.
  - Expect outputs at reset values without a clock edge.
  - After release, a new req0 add 1+1 returns 2 with normal latency.
